// File: rtl/debounce3_sync.sv
// Three-channel 2-flop synchroniser + debouncer feeding the 3-input AND gate; A/B/C are registered levels, chg pulses on toggle.
// Latency: capture edge + STABLE_CYCLES + 1 edges; no backpressure, en=0 freezes outputs while synchronisers keep sampling.
module debounce3_sync #(
  parameter int unsigned CNT_W         = 4,
  parameter int unsigned STABLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       A_raw,
  input  logic       B_raw,
  input  logic       C_raw,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic [2:0] chg
);

  if ((STABLE_CYCLES < 1) || (STABLE_CYCLES > ((1 << CNT_W) - 1))) begin : g_cfg_err
    $error("debounce3_sync: STABLE_CYCLES must be in 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  // Channel order everywhere: bit2=A, bit1=B, bit0=C.
  logic [2:0]            raw;
  logic [2:0]            s1;
  logic [2:0]            s2;
  logic [2:0]            q;
  logic [2:0]            q_nxt;
  logic [2:0]            chg_q;
  logic [2:0]            chg_nxt;
  logic [2:0][CNT_W-1:0] cnt;
  logic [2:0][CNT_W-1:0] cnt_nxt;

  assign raw = {A_raw, B_raw, C_raw};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // A mismatch run that breaks before reaching LAST drops the count back to zero.
  always_comb begin
    q_nxt   = q;
    cnt_nxt = cnt;
    chg_nxt = '0;
    for (int i = 0; i < 3; i++) begin
      if (!en || (s2[i] == q[i])) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == LAST) begin
        q_nxt[i]   = s2[i];
        cnt_nxt[i] = '0;
        chg_nxt[i] = 1'b1;
      end else begin
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      cnt   <= '0;
      chg_q <= '0;
    end else begin
      q     <= q_nxt;
      cnt   <= cnt_nxt;
      chg_q <= chg_nxt;
    end
  end

  assign A   = q[2];
  assign B   = q[1];
  assign C   = q[0];
  assign chg = chg_q;

endmodule

// File: tb/tb_debounce3_sync.sv
// Directed bench for debounce3_sync: window-based reference model checked every cycle plus hand-computed expectations.
// Inputs change on the falling edge; outputs are read 1 time unit after the falling edge.
module tb_debounce3_sync;

  localparam int N = 8;

  logic       clk;
  logic       rst;
  logic       en;
  logic       A_raw;
  logic       B_raw;
  logic       C_raw;
  logic       A;
  logic       B;
  logic       C;
  logic [2:0] chg;
  logic       A1;
  logic       B1;
  logic       C1;
  logic [2:0] chg1;

  int errors = 0;
  int checks = 0;

  debounce3_sync #(.CNT_W(4), .STABLE_CYCLES(N)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .A_raw (A_raw),
    .B_raw (B_raw),
    .C_raw (C_raw),
    .A     (A),
    .B     (B),
    .C     (C),
    .chg   (chg)
  );

  // Boundary configuration: a single mismatching cycle is enough.
  debounce3_sync #(.CNT_W(4), .STABLE_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .A_raw (A_raw),
    .B_raw (B_raw),
    .C_raw (C_raw),
    .A     (A1),
    .B     (B1),
    .C     (C1),
    .chg   (chg1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: an output flips when the last N edges were all enabled and
  // all saw a synchronised level (raw from two edges earlier) opposite to it.
  bit [2:0] m_out;
  bit [2:0] m_chg;
  bit [2:0] raw_hist[$];
  bit [2:0] s2_win[$];
  bit       en_win[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out = '0;
      m_chg = '0;
      raw_hist.delete();
      raw_hist.push_back(3'b000);
      raw_hist.push_back(3'b000);
      s2_win.delete();
      en_win.delete();
    end else begin
      bit [2:0] used;
      bit       all_hit;
      used = raw_hist.pop_front();
      raw_hist.push_back({A_raw, B_raw, C_raw});
      s2_win.push_back(used);
      en_win.push_back(en);
      if (s2_win.size() > N) begin
        void'(s2_win.pop_front());
        void'(en_win.pop_front());
      end
      m_chg = '0;
      if (s2_win.size() == N) begin
        for (int ch = 0; ch < 3; ch++) begin
          all_hit = 1'b1;
          for (int j = 0; j < N; j++)
            if (!en_win[j] || (s2_win[j][ch] == m_out[ch])) all_hit = 1'b0;
          if (all_hit) begin
            m_out[ch] = ~m_out[ch];
            m_chg[ch] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    chk("model_out", {A, B, C}, m_out);
    chk("model_chg", chg, m_chg);
  end

  task automatic hold_b_quiet(input int n);
    for (int k = 0; k < n; k++) begin
      tick(1);
      chk("bounce_b", {2'b00, B}, 3'b000);
      chk("bounce_chg", chg, 3'b000);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b1; A_raw = 1'b0; B_raw = 1'b0; C_raw = 1'b0;
    tick(3);
    chk("rst_hold_out", {A, B, C}, 3'b000);
    chk("rst_hold_chg", chg, 3'b000);
    rst = 1'b0;

    // All three high so reset can be seen clearing ones.
    {A_raw, B_raw, C_raw} = 3'b111;
    tick(9);
    chk("all_pre", {A, B, C}, 3'b000);
    tick(1);
    chk("all_rise", {A, B, C}, 3'b111);
    chk("all_chg", chg, 3'b111);
    tick(1);
    chk("all_chg_clr", chg, 3'b000);
    tick(2);

    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out", {A, B, C}, 3'b000);
    chk("arst_chg", chg, 3'b000);
    {A_raw, B_raw, C_raw} = 3'b000;
    tick(3);
    chk("arst_stay", {A, B, C}, 3'b000);
    rst = 1'b0;
    tick(4);
    chk("idle_out", {A, B, C}, 3'b000);
    chk("n1_idle", {A1, B1, C1}, 3'b000);

    // Clean rising edge on A, captured at edge 0.
    A_raw = 1'b1;
    tick(2);
    chk("n1_pre", {A1, B1, C1}, 3'b000);
    tick(1);
    chk("n1_rise", {A1, B1, C1}, 3'b100);
    chk("n1_chg", chg1, 3'b100);
    chk("clean_mid", {A, B, C}, 3'b000);
    tick(6);
    chk("clean_pre", {A, B, C}, 3'b000);
    chk("clean_pre_chg", chg, 3'b000);
    tick(1);
    chk("clean_rise", {A, B, C}, 3'b100);
    chk("clean_chg", chg, 3'b100);
    tick(1);
    chk("clean_chg_clr", chg, 3'b000);

    // Bounce on B: 7 high, 1 low, 7 high, then low.
    B_raw = 1'b1; hold_b_quiet(7);
    B_raw = 1'b0; hold_b_quiet(1);
    B_raw = 1'b1; hold_b_quiet(7);
    B_raw = 1'b0; hold_b_quiet(12);

    // Simultaneous falling edges on A and C.
    C_raw = 1'b1;
    tick(12);
    chk("c_up", {A, B, C}, 3'b101);
    A_raw = 1'b0; C_raw = 1'b0;
    tick(9);
    chk("fall_pre", {A, B, C}, 3'b101);
    chk("fall_pre_chg", chg, 3'b000);
    tick(1);
    chk("fall_out", {A, B, C}, 3'b000);
    chk("fall_chg", chg, 3'b101);
    tick(1);
    chk("fall_chg_clr", chg, 3'b000);

    // Enable gating.
    en = 1'b0; C_raw = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      chk("en_off_c", {2'b00, C}, 3'b000);
    end
    en = 1'b1;
    tick(N - 1);
    chk("en_on_pre", {A, B, C}, 3'b000);
    tick(1);
    chk("en_on_rise", {A, B, C}, 3'b001);
    chk("en_on_chg", chg, 3'b001);
    tick(1);

    // Reset in the middle of A's count; C_raw is still high.
    A_raw = 1'b1;
    tick(6);
    chk("mid_pre_rst", {A, B, C}, 3'b001);
    rst = 1'b1;
    tick(1);
    chk("mid_rst", {A, B, C}, 3'b000);
    rst = 1'b0;
    tick(9);
    chk("mid_post_pre", {A, B, C}, 3'b000);
    tick(1);
    chk("mid_post_rise", {A, B, C}, 3'b101);
    chk("mid_post_chg", chg, 3'b101);
    tick(1);
    chk("mid_post_clr", chg, 3'b000);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce3_sync.md
Name: debounce3_sync

Overview:
- Input-conditioning stage directly upstream of the team's 3-input AND gate.
- Takes three raw, asynchronous, possibly bouncing signals and synchronises each to clk.
- Debounces each channel independently and presents clean registered levels A, B, C for the gate to combine into Y.
- Also emits a one-cycle change pulse per channel for downstream event logic.

Parameters:
- CNT_W, 4, width of each per-channel stability counter.
- STABLE_CYCLES, 8, consecutive cycles a synchronised level must differ from the current output before the output follows it. Legal range 1..(2^CNT_W - 1); out-of-range values are a configuration error.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  debounce enable; 0 freezes outputs.
- A_raw  input  1  raw asynchronous input, channel A.
- B_raw  input  1  raw asynchronous input, channel B.
- C_raw  input  1  raw asynchronous input, channel C.
- A  output  1  debounced, registered level, channel A (drives AND input A).
- B  output  1  debounced, registered level, channel B.
- C  output  1  debounced, registered level, channel C.
- chg  output  3  one-cycle pulse on output toggle; bit2=A, bit1=B, bit0=C.

Behaviour:
- Reset: one clock; async active-high rst. While rst=1, every flop clears immediately, independent of clk: sync stages s1/s2, A/B/C, all counters, chg. All outputs read 0 during and after reset. Releasing reset mid-bounce gives no special treatment; debounce starts from 0.
- Per channel (identical, independent), 2-flop synchroniser: s1 <= raw; s2 <= s1. Only s2 feeds debounce logic.
- Per-channel counter cnt (CNT_W bits), evaluated each rising edge when en=1:
  - If s2 == out: cnt <= 0; chg bit <= 0.
  - If s2 != out and cnt == STABLE_CYCLES-1: out <= s2; cnt <= 0; chg bit <= 1.
  - Otherwise (s2 != out): cnt <= cnt+1; chg bit <= 0.
- Latency: raw level first captured into s1 at edge 0 → s2 at edge 1 → out toggles and chg pulses at edge STABLE_CYCLES+1. Default is edge 9.
- Glitch rejection: any mismatch run shorter than STABLE_CYCLES cycles at s2 returns cnt to 0 and leaves out unchanged. Partial counts never accumulate across runs.
- cnt never exceeds STABLE_CYCLES-1, so it cannot wrap.
- chg: registered, high for exactly one cycle, asserted on the same edge the output changes. Both rising and falling output changes pulse.
- en=0: synchronisers keep sampling; cnt <= 0; out holds; chg <= 0.
- en 0→1: debouncing restarts from cnt=0, so a full STABLE_CYCLES run is required.
- Simultaneous events: channels are fully independent. Any combination of chg bits may assert in the same cycle.
- STABLE_CYCLES=1: out follows s2 one edge after a mismatch appears; latency is 2 edges from capture.
- No combinational path from any raw input to any output.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with all outputs at 1 → A=B=C=0, chg=000 before the next clk edge; stay 0 while rst=1.
- Clean edge, defaults: A_raw 0→1, captured at edge 0, held → A=1 and chg=100 at edge 9 only; chg=000 at edge 10; B and C unchanged.
- Bounce rejection: B_raw high for 7 cycles, low 1, high 7, then low → B stays 0, chg stays 000 throughout.
- Falling edge plus simultaneity: A and C at 1; drop A_raw and C_raw on the same cycle, hold 12 cycles → A=C=0 with chg=101 at the same edge, 9 edges after capture.
- Enable gating: en=0, C_raw 0→1 held 20 cycles → C stays 0. Raise en → C=1 exactly STABLE_CYCLES edges after the en rise (s2 already settled).
- Reset mid-count: A_raw high; assert rst at edge 5 of count, release, keep A_raw high → A rises 9 edges after the first post-reset capture, not earlier.
